spi_master_gen2: RTL and testbench

Parametrised next-generation SPI master engine. Adds configurable word width, per-transfer bit length, all four CPOL/CPHA modes, MSB/LSB-first ordering, multiple one-hot chip selects and chip-select hold for multi-word frames. It sits under the AXI register wrapper, which latches `irq` and drives the configuration inputs.

---
 rtl/spi_master_gen2.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_master_gen2.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen2.sv
// spi_master_gen2: SPI master engine with per-transfer length, CPOL/CPHA, bit order and CS hold.
// Latency: start accepted at edge 0, done/irq pulse in cycle 1 + D*(2L+2), ready again the cycle after.
// Backpressure: start is taken only while ready=1; requests while busy are dropped, nothing is queued.
module spi_master_gen2 #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_CS          = 4,
  parameter int DIV_WIDTH       = 16,
  parameter int DEFAULT_CLK_DIV = 4,
  localparam int LEN_W          = $clog2(DATA_WIDTH) + 1,
  localparam int CS_W           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [LEN_W-1:0]      bit_len,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  hold_cs,
  input  logic [DIV_WIDTH-1:0]  clk_div_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sclk,
  output logic [NUM_CS-1:0]     cs_n
);

  localparam int EC_W = LEN_W + 1;
  localparam logic [LEN_W-1:0]      LEN_MAX  = LEN_W'(DATA_WIDTH);
  localparam logic [LEN_W-1:0]      LEN_ONE  = LEN_W'(1);
  localparam logic [EC_W-1:0]       EC_ONE   = EC_W'(1);
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]  DIV_MIN  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0]  DIV_DEF  = DIV_WIDTH'(DEFAULT_CLK_DIV);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  // Per-transfer configuration, frozen at the accepting start edge
  logic [DATA_WIDTH-1:0] tx_q;
  logic [LEN_W-1:0]      len_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  lsb_q;
  logic [CS_W-1:0]       sel_q;
  logic                  hold_q;
  logic [DIV_WIDTH-1:0]  div_q;

  // Timing and shift state
  logic [DIV_WIDTH-1:0]  cnt;
  logic [EC_W-1:0]       edge_cnt;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  held;

  // Derived control
  logic                  tick;
  logic                  last_edge;
  logic [EC_W-1:0]       two_len;
  logic [LEN_W-1:0]      len_in;
  logic [DIV_WIDTH-1:0]  div_in;
  logic                  first_bit;
  logic [LEN_W-1:0]      bit_j;
  logic [LEN_W-1:0]      drv_j;
  logic [LEN_W-1:0]      tx_idx;
  logic                  drv_bit;
  logic                  odd_edge;
  logic                  sample_now;

  // Active-low one-hot select; an out-of-range index selects nothing
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  // Input decode for the accepting edge and per-edge bit selection during SHIFT
  always_comb begin
    len_in = bit_len;
    if (bit_len == '0 || bit_len > LEN_MAX) len_in = LEN_MAX;
    div_in    = (clk_div_in >= DIV_MIN) ? clk_div_in : DIV_DEF;
    first_bit = lsb_first ? tx_data[0] : |(tx_data & (DATA_ONE << (len_in - LEN_ONE)));

    tick      = (cnt == div_q - DIV_ONE);
    two_len   = {len_q, 1'b0};
    last_edge = (edge_cnt == two_len - EC_ONE);
    // edge_cnt holds the edges already made, so the upcoming edge is edge_cnt+1
    odd_edge   = ~edge_cnt[0];
    sample_now = odd_edge ^ cpha_q;
    bit_j      = edge_cnt[EC_W-1:1];
    // cpha=0 already put bit j out before its sample edge, so its drive edge carries bit j+1
    drv_j      = cpha_q ? bit_j : bit_j + LEN_ONE;
    tx_idx     = lsb_q ? drv_j : (len_q - LEN_ONE - drv_j);
    drv_bit    = |(tx_q & (DATA_ONE << tx_idx));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status decode
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = ST_SETUP;
      end
      ST_SETUP: if (tick) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && last_edge) state_nxt = ST_HOLD;
      ST_HOLD:  if (tick) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy = ~ready;
    irq  = done;
  end

  // Latch the transfer configuration when a start is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q   <= '0;
      len_q  <= LEN_MAX;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      sel_q  <= '0;
      hold_q <= 1'b0;
      div_q  <= DIV_DEF;
    end else if (state == ST_IDLE && start) begin
      tx_q   <= tx_data;
      len_q  <= len_in;
      cpol_q <= cpol;
      cpha_q <= cpha;
      lsb_q  <= lsb_first;
      sel_q  <= cs_sel;
      hold_q <= hold_cs;
      div_q  <= div_in;
    end
  end

  // Half-period divider: counts 0..D-1 in every timed state, parked at 0 otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt <= '0;
    else if (state == ST_IDLE || state == ST_DONE) cnt <= '0;
    else if (tick)                               cnt <= '0;
    else                                         cnt <= cnt + DIV_ONE;
  end

  // SCLK edge counter for the SHIFT phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              edge_cnt <= '0;
    else if (state == ST_IDLE)              edge_cnt <= '0;
    else if (state == ST_SHIFT && tick)     edge_cnt <= edge_cnt + EC_ONE;
  end

  // Serial datapath: SCLK, MOSI, receive shifter and the rx_data result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_sh   <= '0;
      rx_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sclk <= cpol_q;
          mosi <= 1'b0;
          if (start) begin
            sclk  <= cpol;
            mosi  <= cpha ? 1'b0 : first_bit;
            rx_sh <= '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (sample_now) begin
              if (lsb_q) rx_sh <= rx_sh | (DATA_WIDTH'(miso) << bit_j);
              else       rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
            end else if (drv_j < len_q) begin
              mosi <= drv_bit;
            end
          end
        end
        ST_HOLD: begin
          sclk <= cpol_q;
          if (tick) rx_data <= rx_sh;
        end
        ST_DONE: mosi <= 1'b0;
        default: ;
      endcase
    end
  end

  // Chip-select drive and the held-CS flag carried across frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n <= '1;
      held <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // A different target drops the held CS first; SETUP asserts the new one next cycle
            if (held && cs_sel != sel_q) begin
              cs_n <= '1;
              held <= 1'b0;
            end else begin
              cs_n <= cs_mask(cs_sel);
            end
          end
        end
        ST_SETUP, ST_SHIFT: cs_n <= cs_mask(sel_q);
        ST_HOLD: begin
          if (tick) begin
            held <= hold_q;
            if (!hold_q) cs_n <= '1;
          end else begin
            cs_n <= cs_mask(sel_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Bench for spi_master_gen2: directed and random transfers against a pin-level SPI slave model.
// Checks latency, edge count, half period, MOSI order, rx_data, chip selects and idle levels.
// Start is pulsed, held high or spammed while busy to cover acceptance rules.
module tb_spi_master_gen2;

  localparam int NCS = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] tx_data;
  logic [5:0]  bit_len;
  logic        cpol, cpha, lsb_first;
  logic [1:0]  cs_sel;
  logic        hold_cs;
  logic [15:0] clk_div_in;
  logic [31:0] rx_data;
  logic        ready, busy, done, irq;
  logic        miso, mosi, sclk;
  logic [3:0]  cs_n;

  logic        loop_en;
  logic        miso_drv;
  int          n_tests;
  int          n_fail;
  bit          m_held;
  int          m_held_sel;

  assign miso = loop_en ? mosi : miso_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_master_gen2 dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .bit_len(bit_len),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel), .hold_cs(hold_cs),
    .clk_div_in(clk_div_in), .rx_data(rx_data), .ready(ready), .busy(busy), .done(done),
    .irq(irq), .miso(miso), .mosi(mosi), .sclk(sclk), .cs_n(cs_n)
  );

  function automatic logic [3:0] sel_mask(input int sel);
    logic [3:0] m;
    m = 4'hF;
    if (sel >= 0 && sel < NCS) m[sel] = 1'b0;
    return m;
  endfunction

  function automatic int eff_len(input int blen);
    return (blen == 0 || blen > 32) ? 32 : blen;
  endfunction

  function automatic int eff_div(input int div);
    return (div >= 2) ? div : 4;
  endfunction

  // Bit j of a word in transmission order
  function automatic logic order_bit(input logic [31:0] w, input int j, input int L, input bit lsb);
    return lsb ? w[j] : w[L-1-j];
  endfunction

  // One complete transfer observed at the pins; the slave answers with sw (or loops mosi back)
  task automatic xfer(input string name, input logic [31:0] tx, input int blen,
                      input bit pol, input bit pha, input bit lsb, input int sel, input bit hld,
                      input int div, input logic [31:0] sw, input bit loop,
                      input bit keep, input bit pulses);
    int L, D, T, edges, first_e, half, done_cyc, j;
    logic [31:0] exp_cap, cap, src, exp_rx, rx_done;
    logic [3:0]  cs1_exp, cs_done_exp, cs_done;
    bit cs_err, stat_err, prev, odd;
    L = eff_len(blen);
    D = eff_div(div);
    T = 1 + D * (2 * L + 2);
    exp_cap = '0;
    for (int b = 0; b < L; b++) exp_cap[b] = order_bit(tx, b, L, lsb);
    src    = loop ? tx : sw;
    exp_rx = (L == 32) ? src : (src & ((32'h1 << L) - 32'h1));
    cs1_exp     = (m_held && m_held_sel != sel) ? 4'hF : sel_mask(sel);
    cs_done_exp = hld ? sel_mask(sel) : 4'hF;

    tx_data = tx; bit_len = 6'(blen); cpol = pol; cpha = pha; lsb_first = lsb;
    cs_sel = 2'(sel); hold_cs = hld; clk_div_in = 16'(div);
    loop_en  = loop;
    miso_drv = pha ? 1'b0 : order_bit(sw, 0, L, lsb);
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep) start = 1'b0;

    n_tests++;
    if ({busy, ready, cs_n, sclk, mosi} !== {1'b1, 1'b0, cs1_exp, pol, pha ? 1'b0 : exp_cap[0]}) begin
      n_fail++;
      $display("FAIL %s_cycle1: busy,ready,cs_n,sclk,mosi got %b,%b,%b,%b,%b want 1,0,%b,%b,%b",
               name, busy, ready, cs_n, sclk, mosi, cs1_exp, pol, pha ? 1'b0 : exp_cap[0]);
    end

    prev = sclk; edges = 0; first_e = 0; half = -1; done_cyc = -1;
    cap = '0; cs_err = 0; stat_err = 0; rx_done = '0; cs_done = '0;
    for (int cyc = 2; cyc <= T + 20; cyc++) begin
      // mid-transfer input changes must not matter
      tx_data = $urandom; bit_len = 6'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
      lsb_first = 1'($urandom); cs_sel = 2'($urandom); hold_cs = 1'($urandom);
      clk_div_in = 16'($urandom_range(0, 7));
      if (pulses) start = (cyc == 5 || cyc == 12 || cyc == 19);
      @(posedge clk); #1;
      if (busy !== ~ready || irq !== done) stat_err = 1;
      if (sclk !== prev) begin
        edges++;
        if (edges == 1) first_e = cyc;
        if (edges == 2) half = cyc - first_e;
        odd = (edges % 2) == 1;
        if (odd != pha) begin
          j = (edges - 1) / 2;
          if (j < 32) cap[j] = mosi;
        end else begin
          j = pha ? (edges - 1) / 2 : edges / 2;
          if (j < L) miso_drv = order_bit(sw, j, L, lsb);
        end
        prev = sclk;
      end
      if (done === 1'b1) begin
        done_cyc = cyc; rx_done = rx_data; cs_done = cs_n;
        break;
      end else if (cs_n !== sel_mask(sel)) begin
        cs_err = 1;
      end
    end

    n_tests++;
    if (done_cyc != T) begin
      n_fail++; $display("FAIL %s_done_latency: got cycle %0d want %0d", name, done_cyc, T);
    end
    n_tests++;
    if (edges != 2 * L) begin
      n_fail++; $display("FAIL %s_sclk_edges: got %0d want %0d", name, edges, 2 * L);
    end
    n_tests++;
    if (half != D) begin
      n_fail++; $display("FAIL %s_half_period: got %0d want %0d", name, half, D);
    end
    n_tests++;
    if (cap !== exp_cap) begin
      n_fail++; $display("FAIL %s_mosi_bits: got %h want %h", name, cap, exp_cap);
    end
    n_tests++;
    if (rx_done !== exp_rx) begin
      n_fail++; $display("FAIL %s_rx_data: got %h want %h", name, rx_done, exp_rx);
    end
    n_tests++;
    if (cs_err || stat_err) begin
      n_fail++; $display("FAIL %s_during: cs_err %0d status_err %0d want 0 0", name, cs_err, stat_err);
    end
    n_tests++;
    if (cs_done !== cs_done_exp) begin
      n_fail++; $display("FAIL %s_cs_at_done: got %b want %b", name, cs_done, cs_done_exp);
    end

    @(posedge clk); #1;
    n_tests++;
    if ({ready, done, mosi, sclk, cs_n, rx_data} !== {1'b1, 1'b0, 1'b0, pol, cs_done_exp, exp_rx}) begin
      n_fail++;
      $display("FAIL %s_idle_after: ready,done,mosi,sclk,cs_n,rx got %b,%b,%b,%b,%b,%h want 1,0,0,%b,%b,%h",
               name, ready, done, mosi, sclk, cs_n, rx_data, pol, cs_done_exp, exp_rx);
    end
    m_held     = hld;
    m_held_sel = sel;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tx_data = '0; bit_len = '0; cpol = 1'b1; cpha = 1'b0;
    lsb_first = 1'b0; cs_sel = '0; hold_cs = 1'b0; clk_div_in = '0; loop_en = 1'b0; miso_drv = 1'b0;
    m_held = 0; m_held_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ready, busy, done, irq, rx_data, mosi, sclk, cs_n} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_state: ready,busy,done,irq,rx,mosi,sclk,cs_n got %b,%b,%b,%b,%h,%b,%b,%b want 1,0,0,0,0,0,0,1111",
               ready, busy, done, irq, rx_data, mosi, sclk, cs_n);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ready, sclk, cs_n} !== {1'b1, 1'b0, 4'hF}) begin
      n_fail++; $display("FAIL reset_idle_cpol: ready,sclk,cs_n got %b,%b,%b want 1,0,1111", ready, sclk, cs_n);
    end
  endtask

  task automatic test_modes();
    xfer("mode0_a5", 32'h0000_00A5, 8, 0, 0, 0, 0, 0, 4, 32'h0, 1, 0, 0);
    xfer("mode3_lsb", 32'h0000_1234, 16, 1, 1, 1, 1, 0, 2, 32'h0000_BEEF, 0, 0, 0);
    xfer("mode3_again", 32'h0000_5A0F, 12, 1, 1, 0, 3, 0, 3, 32'h0000_0C3A, 0, 0, 0);
    xfer("mode1", 32'h8000_0001, 32, 0, 1, 0, 2, 0, 2, 32'h1357_9BDF, 0, 0, 0);
    xfer("mode2", 32'h0000_0096, 8, 1, 0, 1, 0, 0, 2, 32'h0000_0069, 0, 0, 0);
  endtask

  task automatic test_lengths();
    xfer("len5", 32'h0000_0013, 5, 0, 0, 0, 0, 0, 2, 32'h0, 1, 0, 0);
    xfer("len0", 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 2, 32'h0, 1, 0, 0);
    xfer("len40", 32'hCAFE_F00D, 40, 0, 1, 1, 1, 0, 2, 32'h0BAD_C0DE, 0, 0, 0);
    xfer("len1", 32'h0000_0001, 1, 1, 0, 0, 3, 0, 5, 32'h0000_0001, 0, 0, 0);
  endtask

  task automatic test_start_handling();
    bit err;
    xfer("busy_pulses", 32'h0000_003C, 8, 0, 0, 0, 0, 0, 1, 32'h0000_00C5, 0, 0, 1);
    start = 1'b0;
    err = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || ready !== 1'b1) err = 1;
    end
    n_tests++;
    if (err) begin
      n_fail++; $display("FAIL no_queue: got done/ready activity after busy pulses, want idle");
    end
    xfer("held_start1", 32'h0000_00F0, 6, 0, 0, 0, 1, 0, 1, 32'h0000_0011, 0, 1, 0);
    xfer("held_start2", 32'h0000_0022, 6, 0, 1, 0, 1, 0, 1, 32'h0000_002D, 0, 0, 0);
  endtask

  task automatic test_hold_cs();
    xfer("hold_w1", 32'h0000_00AB, 8, 0, 0, 0, 2, 1, 2, 32'h0000_0044, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (cs_n !== 4'b1011) begin
      n_fail++; $display("FAIL hold_between: cs_n got %b want 1011", cs_n);
    end
    xfer("hold_w2", 32'h0000_00CD, 8, 0, 0, 0, 2, 0, 2, 32'h0000_0077, 0, 0, 0);
    xfer("hold_w3", 32'h0000_0011, 8, 0, 0, 0, 2, 1, 2, 32'h0000_0022, 0, 0, 0);
    xfer("switch_cs", 32'h0000_0033, 8, 0, 0, 0, 1, 0, 2, 32'h0000_0055, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int  edges;
    bit  prev, err;
    tx_data = 32'hC3C3_5A5A; bit_len = 6'd8; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = 2'd3; hold_cs = 1'b0; clk_div_in = 16'd4; loop_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = sclk; edges = 0;
    for (int c = 0; c < 200 && edges < 6; c++) begin
      @(posedge clk); #1;
      if (sclk !== prev) begin
        edges++;
        prev = sclk;
      end
    end
    n_tests++;
    if (edges != 6) begin
      n_fail++; $display("FAIL rst_mid_reach: edges got %0d want 6", edges);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({cs_n, sclk, mosi, busy, ready, done, irq} !== {4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_now: cs_n,sclk,mosi,busy,ready,done,irq got %b,%b,%b,%b,%b,%b,%b want 1111,0,0,0,1,0,0",
               cs_n, sclk, mosi, busy, ready, done, irq);
    end
    err = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || rx_data !== 32'h0 || sclk !== 1'b0 || ready !== 1'b1) err = 1;
    end
    reset = 1'b0;
    m_held = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) err = 1;
    end
    n_tests++;
    if (err) begin
      n_fail++; $display("FAIL rst_mid_quiet: got done/busy/rx activity after reset, want none");
    end
    xfer("after_reset", 32'h0000_00E7, 8, 0, 0, 0, 3, 0, 4, 32'h0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      xfer("rand", $urandom, int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
           $urandom, 1'($urandom), 0, 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_modes();
    test_lengths();
    test_start_handling();
    test_hold_cs();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
